multi_clock_gen: RTL and testbench
==================================

# multi_clock_gen

Multi-channel, parametrised clock and tick generator. It replaces single-channel fixed dividers across the design. Each of NUM_CH channels divides the system clock by a runtime-programmable count and produces two outputs: a 50 % toggle clock or registered strobe, and a one-cycle tick. Divider values are written through a valid/ready config port. Reloads are glitch-free, and a common sync input phase-aligns all channels.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 32, divider counter / delay width
- DEFAULT_DELAY, 0, delay value loaded into every channel at reset
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel enable
- mode  in  NUM_CH  per-channel output mode: 0 = toggle clock, 1 = pulse
- sync  in  1  restarts all enabled channels from phase 0
- cfg_valid  in  1  config write request
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_delay  in  CNT_W  new delay value
- cfg_ready  out  1  write can be accepted for cfg_ch
- clk_out  out  NUM_CH  divided clock (mode 0) or registered pulse (mode 1)
- tick  out  NUM_CH  one-cycle strobe per terminal event

## Operation
- Per-channel state: counter[CNT_W], delay_reg[CNT_W], pending flag, pending_delay[CNT_W], clk_out, tick. All are registered.
- Terminal event: en=1, no sync, and counter >= delay_reg at a clock edge.
- At a terminal event:
  - counter <= 0 and tick <= 1.
  - Mode 0: clk_out toggles.
  - Mode 1: clk_out <= 1.
- At any other enabled edge: counter <= counter+1, tick <= 0. In mode 1, clk_out <= 0; in mode 0, clk_out holds.
- The `>=` compare is deliberate. It guarantees wrap-around even if counter ever exceeds delay_reg.
- Division: tick period is delay_reg+1 cycles; the mode-0 clk_out period is 2·(delay_reg+1). delay_reg = 0 gives tick every cycle and clk_out = clk/2.
- Disabled (en=0):
  - counter, clk_out and tick are forced to 0 on the next edge.
  - A pending reload is applied immediately.
- Mode change takes effect at the next edge. Changing mode 1→0 leaves clk_out at its current value, then toggles normally.
- Config handshake: cfg_ready = ~pending[cfg_ch] (combinational from registered state). A write is accepted when cfg_valid & cfg_ready, which sets pending and pending_delay.
- Reload point: on an enabled channel, pending_delay is copied to delay_reg at the next terminal event (or a sync), and pending clears on that edge. The current period is always completed with the old value.
- Write with cfg_valid & ~cfg_ready: ignored, no side effect. The master holds cfg_valid until it sees ready.
- cfg_ch ≥ NUM_CH: the write is accepted and discarded; cfg_ready = 1.
- sync=1 at an edge, all enabled channels:
  - counter <= 0, clk_out <= 0, tick <= 0.
  - Any pending reload is applied.
  - sync beats a coincident terminal event: no tick is generated.
- A write accepted in the same cycle as a terminal event for that channel is not applied at that event; it becomes pending and is applied at the following one.

## Timing
- Reset values: counter 0, delay_reg DEFAULT_DELAY, pending 0, clk_out 0, tick 0, cfg_ready 1.
- Reset mid-operation clears everything asynchronously. Outputs are low with no glitch beyond the reset assertion.
- First tick latency: en rises before edge E0 with counter 0. tick is high for the one cycle after edge E0+delay_reg.
- Config latency:
  - Accepted write to a disabled channel: active 1 edge after acceptance.
  - Accepted write to an enabled channel: active at the next terminal event, worst case delay_reg+1 cycles.

## Structure
- Package multi_clock_gen_pkg holds:
  - CH_MODE_TOGGLE/CH_MODE_PULSE constants (1-bit mode typedef).
  - A CNT_W-parametrised delay typedef is not possible in a package, so CNT_W stays a module parameter.
- Sub-module clk_gen_channel: one channel (counter, delay/pending registers, outputs). It is instantiated NUM_CH times in a generate loop.
- The top level holds only the cfg_ch decode, cfg_ready mux and sync fan-out.

## Test plan
- Reset, then delay 3, mode 0, en=1: tick every 4 cycles, clk_out high 4 / low 4; first tick on the cycle after the 4th enabled edge.
- Channel 1 delay 0, mode 0: clk_out = clk/2, tick constant 1 after the first edge. Channel 2 delay 2, mode 1: clk_out pulses 1 cycle in 3, aligned with tick.
- Channel running delay 9; write 1 at counter 4: period completes at 10 cycles, then period 2; cfg_ready low from acceptance until the reload edge.
- Second write to the same channel while pending: cfg_ready=0, write ignored, first value applied. Write to another channel in the same window: accepted.
- sync asserted on the same edge as a terminal count: no tick, all enabled counters 0, clk_out 0; channels phase-aligned afterwards.
- rst_n pulsed low mid-period with a pending reload: all outputs 0 immediately, delay_reg = DEFAULT_DELAY, pending cleared, cfg_ready=1.

Source files
------------

// File: rtl/multi_clock_gen_pkg.sv
// Shared types for the multi-channel clock/tick generator.
package multi_clock_gen_pkg;

    typedef logic ch_mode_t;

    localparam ch_mode_t CH_MODE_TOGGLE = 1'b0;
    localparam ch_mode_t CH_MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_gen_channel.sv
// One divider channel: counter, active/pending delay registers and the
// registered clk_out/tick outputs.
module clk_gen_channel
    import multi_clock_gen_pkg::*;
#(
    parameter int               CNT_W         = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DELAY = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  ch_mode_t         mode,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_delay,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_pend_delay;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_term;
    logic             w_reload;

    // >= rather than == so an oversized counter still wraps.
    assign w_term   = en & ~sync & (r_cnt >= r_delay);
    assign w_reload = r_pend & (~en | sync | w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_delay      <= DEFAULT_DELAY;
            r_pend_delay <= '0;
            r_pend       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            if (!en || sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_term) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_clk_out <= (mode == CH_MODE_PULSE) ? 1'b1 : ~r_clk_out;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
                if (mode == CH_MODE_PULSE)
                    r_clk_out <= 1'b0;
            end

            if (w_reload)
                r_delay <= r_pend_delay;

            // A write is only accepted while nothing is pending, so it never
            // races a reload of the same channel.
            if (wr_en) begin
                r_pend       <= 1'b1;
                r_pend_delay <= wr_delay;
            end else if (w_reload) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pending = r_pend;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock/tick generator: config decode, ready mux
// and sync fan-out around an array of clk_gen_channel instances.
module multi_clock_gen
    import multi_clock_gen_pkg::*;
#(
    parameter int               NUM_CH        = 4,
    parameter int               CNT_W         = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DELAY = '0,
    localparam int              CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_delay,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;

    // Unmatched channel numbers fall through as ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i))
                cfg_ready = ~w_pending[i];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

        clk_gen_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DELAY(DEFAULT_DELAY)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .mode    (mode[g]),
            .sync    (sync),
            .wr_en   (w_wr[g]),
            .wr_delay(cfg_delay),
            .pending (w_pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Directed bench for multi_clock_gen: division, pulse mode, reload timing,
// config handshake, sync alignment and asynchronous reset.
module tb_multi_clock_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic [NUM_CH-1:0] mode = '0;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_delay = '0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    multi_clock_gen #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_DELAY('0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ch   (cfg_ch),
        .cfg_delay(cfg_delay),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: clk_out=%b tick=%b, required 0000/0000", clk_out, tick);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_ch = 2'(c);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready ch%0d: got %b, required 1", c, cfg_ready);
            end
        end
        cfg_ch = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divide_by_4();
        logic exp_t, exp_c;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_delay = 32'd3;
        adv();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL div4_pending_ready: got %b, required 0", cfg_ready);
        end
        adv();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL div4_disabled_reload_ready: got %b, required 1", cfg_ready);
        end
        en[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            adv();
            exp_t = (k % 4 == 3);
            exp_c = (((k + 1) / 4) % 2 == 1);
            checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c) begin
                errors++;
                $display("FAIL div4 edge%0d: tick=%b clk_out=%b, required %b/%b", k, tick[0], clk_out[0], exp_t, exp_c);
            end
        end
        en[0] = 1'b0;
        adv();
        checks++;
        if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL div4_disable: tick=%b clk_out=%b, required 0/0", tick[0], clk_out[0]);
        end
    endtask

    task automatic test_div2_pulse();
        logic e1t, e1c, e2t;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_delay = 32'd0;
        adv();
        cfg_ch = 2'd2; cfg_delay = 32'd2;
        adv();
        cfg_valid = 1'b0; cfg_ch = 2'd0;
        adv();
        en[1] = 1'b1; en[2] = 1'b1; mode[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            adv();
            e1t = 1'b1;
            e1c = (k % 2 == 0);
            e2t = (k % 3 == 2);
            checks++;
            if (tick[1] !== e1t || clk_out[1] !== e1c || tick[2] !== e2t || clk_out[2] !== e2t) begin
                errors++;
                $display("FAIL div2_pulse edge%0d: ch1 tick/clk=%b%b ch2 tick/clk=%b%b, required %b%b %b%b",
                         k, tick[1], clk_out[1], tick[2], clk_out[2], e1t, e1c, e2t, e2t);
            end
        end
        en = '0; mode = '0;
        adv();
    endtask

    task automatic test_reload();
        logic exp_t, exp_r;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_delay = 32'd9;
        adv();
        cfg_valid = 1'b0;
        adv();
        en[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            adv();
            exp_t = (k == 9) || (k > 9 && (k - 9) % 2 == 0);
            if (cfg_ch == 2'd3) exp_r = 1'b0;
            else                exp_r = !(k >= 4 && k <= 8);
            checks++;
            if (tick[0] !== exp_t || cfg_ready !== exp_r) begin
                errors++;
                $display("FAIL reload edge%0d: tick=%b ready=%b, required %b/%b", k, tick[0], cfg_ready, exp_t, exp_r);
            end
            if (k == 3) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_delay = 32'd1;
            end else if (k == 4) begin
                cfg_delay = 32'd7;
            end else if (k == 5) begin
                cfg_ch = 2'd3; cfg_delay = 32'd5;
                #1;
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reload_other_ch_ready: got %b, required 1", cfg_ready);
                end
            end else if (k == 6) begin
                cfg_valid = 1'b0; cfg_ch = 2'd0;
            end
        end
        en[0] = 1'b0;
        adv();
    endtask

    task automatic test_sync();
        logic e0t, e0c, e3t, e3c;
        int j;
        en[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            adv();
            if (k < 5) begin
                e0t = (k % 2 == 1);
                e0c = (((k + 1) / 2) % 2 == 1);
            end else if (k == 5) begin
                e0t = 1'b0; e0c = 1'b0;
            end else begin
                j = k - 6;
                e0t = (j % 2 == 1);
                e0c = (((j + 1) / 2) % 2 == 1);
            end
            e3t = (k == 11);
            e3c = (k == 11);
            checks++;
            if (tick[0] !== e0t || clk_out[0] !== e0c || tick[3] !== e3t || clk_out[3] !== e3c) begin
                errors++;
                $display("FAIL sync edge%0d: ch0 tick/clk=%b%b ch3 tick/clk=%b%b, required %b%b %b%b",
                         k, tick[0], clk_out[0], tick[3], clk_out[3], e0t, e0c, e3t, e3c);
            end
            if (k == 0) en[3] = 1'b1;
            if (k == 4) sync = 1'b1;
            if (k == 5) sync = 1'b0;
        end
        en = '0;
        adv();
    endtask

    task automatic test_reset_mid();
        logic exp_t;
        en[0] = 1'b1; en[1] = 1'b1; cfg_ch = 2'd0;
        for (int k = 0; k < 5; k++) begin
            adv();
            exp_t = (k % 2 == 1);
            checks++;
            if (tick[0] !== exp_t) begin
                errors++;
                $display("FAIL same_edge_write edge%0d: tick=%b, required %b", k, tick[0], exp_t);
            end
            if (k == 0) begin
                cfg_valid = 1'b1; cfg_delay = 32'd6;
            end else if (k == 1) begin
                cfg_valid = 1'b0;
            end else if (k == 3) begin
                cfg_valid = 1'b1; cfg_delay = 32'd2;
            end else if (k == 4) begin
                cfg_valid = 1'b0;
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL pre_reset_pending: ready=%b, required 0", cfg_ready);
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: clk_out=%b tick=%b ready=%b, required 0000/0000/1", clk_out, tick, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            adv();
            checks++;
            if (tick !== 4'b0011 || clk_out !== ((j % 2 == 0) ? 4'b0011 : 4'b0000)) begin
                errors++;
                $display("FAIL post_reset_default edge%0d: tick=%b clk_out=%b, required 0011/%b",
                         j, tick, clk_out, (j % 2 == 0) ? 4'b0011 : 4'b0000);
            end
        end
        en = '0;
        adv();
    endtask

    initial begin
        test_reset();
        test_divide_by_4();
        test_div2_pulse();
        test_reload();
        test_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
